// File: rtl/main_fsm_wb_if.sv
// Signal bundle between the cache main control FSM and the pipeline / AXI-bridge side.
// The master modport belongs to the FSM; the slave modport belongs to its environment.
interface main_fsm_wb_if #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned CNT_W = 32
);
    logic             valid;
    logic             op;
    logic             uncached;
    logic             cache_hit;
    logic [WAYS-1:0]  hit;
    logic [WAYS-1:0]  lru_way_sel;
    logic             victim_dirty;
    logic             r_rdy_AXI;
    logic             fill_finish;
    logic             w_rdy_AXI;
    logic             wb_done;
    logic             cnt_clr;

    logic [WAYS-1:0]  way_visit;
    logic             mbuf_we;
    logic             pbuf_we;
    logic             rbuf_we;
    logic             wbuf_we;
    logic             rdata_sel;
    logic             way_sel_en;
    logic [WAYS-1:0]  mem_we;
    logic [WAYS-1:0]  tagv_we;
    logic [WAYS-1:0]  dirty_we;
    logic             r_req;
    logic             w_req;
    logic             r_data_ready;
    logic             data_valid;
    logic             cache_ready;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        input  valid, op, uncached, cache_hit, hit, lru_way_sel, victim_dirty,
               r_rdy_AXI, fill_finish, w_rdy_AXI, wb_done, cnt_clr,
        output way_visit, mbuf_we, pbuf_we, rbuf_we, wbuf_we, rdata_sel, way_sel_en,
               mem_we, tagv_we, dirty_we, r_req, w_req, r_data_ready, data_valid,
               cache_ready, hit_cnt, miss_cnt
    );

    modport slave (
        output valid, op, uncached, cache_hit, hit, lru_way_sel, victim_dirty,
               r_rdy_AXI, fill_finish, w_rdy_AXI, wb_done, cnt_clr,
        input  way_visit, mbuf_we, pbuf_we, rbuf_we, wbuf_we, rdata_sel, way_sel_en,
               mem_we, tagv_we, dirty_we, r_req, w_req, r_data_ready, data_valid,
               cache_ready, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/main_fsm_wb.sv
// Main control FSM for an N-way write-back cache with uncached bypass and saturating
// hit/miss counters. Outputs are Mealy-style, decoded from state and inputs.
module main_fsm_wb #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned CNT_W = 32
) (
    input logic           clk,
    input logic           rst,
    main_fsm_wb_if.master bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS      = 3'd2,
        WRITEBACK = 3'd3,
        WB_WAIT   = 3'd4,
        REPLACE   = 3'd5,
        REFILL    = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_hit_inc;
    logic             w_miss_inc;
    logic             w_unc_store;
    logic [WAYS-1:0]  w_victim;

    assign w_unc_store = bus.uncached & bus.op;
    assign w_victim    = bus.lru_way_sel;
    assign w_hit_inc   = (r_state == LOOKUP) & ~bus.uncached &  bus.cache_hit;
    assign w_miss_inc  = (r_state == LOOKUP) & ~bus.uncached & ~bus.cache_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:      w_next_state = bus.valid ? LOOKUP : IDLE;
            LOOKUP: begin
                if (bus.uncached) begin
                    w_next_state = bus.op ? WRITEBACK : REPLACE;
                end else if (bus.cache_hit) begin
                    w_next_state = bus.valid ? LOOKUP : IDLE;
                end else begin
                    w_next_state = MISS;
                end
            end
            MISS:      w_next_state = bus.victim_dirty ? WRITEBACK : REPLACE;
            WRITEBACK: w_next_state = bus.w_rdy_AXI ? WB_WAIT : WRITEBACK;
            WB_WAIT: begin
                if (!bus.wb_done) begin
                    w_next_state = WB_WAIT;
                end else if (w_unc_store) begin
                    w_next_state = bus.valid ? LOOKUP : IDLE;
                end else begin
                    w_next_state = REPLACE;
                end
            end
            REPLACE:   w_next_state = bus.r_rdy_AXI ? REFILL : REPLACE;
            REFILL: begin
                if (bus.fill_finish) begin
                    w_next_state = bus.valid ? LOOKUP : IDLE;
                end else begin
                    w_next_state = REFILL;
                end
            end
            default:   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.way_visit    = '0;
        bus.mbuf_we      = 1'b0;
        bus.pbuf_we      = 1'b0;
        bus.rbuf_we      = 1'b0;
        bus.wbuf_we      = 1'b0;
        bus.rdata_sel    = 1'b0;
        bus.way_sel_en   = 1'b0;
        bus.mem_we       = '0;
        bus.tagv_we      = '0;
        bus.dirty_we     = '0;
        bus.r_req        = 1'b0;
        bus.w_req        = 1'b0;
        bus.r_data_ready = 1'b0;
        bus.data_valid   = 1'b0;
        bus.cache_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                bus.rbuf_we     = 1'b1;
                bus.cache_ready = 1'b1;
            end
            LOOKUP: begin
                bus.rdata_sel = 1'b1;
                bus.pbuf_we   = 1'b1;
                // Uncached requests ignore the tag compare and always take the miss path.
                if (bus.uncached || !bus.cache_hit) begin
                    bus.mbuf_we = 1'b1;
                end else begin
                    bus.data_valid  = 1'b1;
                    bus.rbuf_we     = 1'b1;
                    bus.cache_ready = 1'b1;
                    bus.way_visit   = bus.hit;
                    bus.way_sel_en  = 1'b1;
                    if (bus.op) begin
                        bus.mem_we   = bus.hit;
                        bus.dirty_we = bus.hit;
                    end
                end
            end
            MISS:      bus.wbuf_we = bus.victim_dirty;
            WRITEBACK: bus.w_req   = 1'b1;
            WB_WAIT: begin
                if (bus.wb_done && w_unc_store) begin
                    bus.data_valid  = 1'b1;
                    bus.rbuf_we     = 1'b1;
                    bus.cache_ready = 1'b1;
                end
            end
            REPLACE:   bus.r_req = 1'b1;
            REFILL: begin
                bus.r_data_ready = 1'b1;
                if (bus.fill_finish) begin
                    bus.data_valid  = 1'b1;
                    bus.rbuf_we     = 1'b1;
                    bus.cache_ready = 1'b1;
                    if (!bus.uncached) begin
                        bus.mem_we     = w_victim;
                        bus.tagv_we    = w_victim;
                        bus.dirty_we   = w_victim;
                        bus.way_visit  = w_victim;
                        bus.way_sel_en = 1'b1;
                    end
                end
            end
            default: begin
                bus.rbuf_we     = 1'b1;
                bus.cache_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_inc && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss_inc && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
endmodule

// File: tb/tb_main_fsm_wb.sv
// Self-checking bench for main_fsm_wb: directed vector table, hand-written reset and
// counter-saturation sequences, then random traffic against a transaction-level model.
module tb_main_fsm_wb;
    localparam int unsigned WAYS    = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    main_fsm_wb_if #(.WAYS(WAYS), .CNT_W(CNT_W)) bus ();
    main_fsm_wb #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0] way_visit;
        logic       mbuf, pbuf, rbuf, wbuf, rdata_sel, way_sel_en;
        logic [3:0] mem_we, tagv_we, dirty_we;
        logic       r_req, w_req, r_data_ready, data_valid, cache_ready;
    } out_t;

    typedef struct packed {
        logic       valid, op, unc, chit;
        logic [3:0] hit, lru;
        logic       vd, rrdy, ff, wrdy, wbd, clr;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        out_t        exp;
        int unsigned hc;
        int unsigned mc;
    } vec_t;

    typedef enum {P_IDLE, P_LOOK, P_MISS, P_WB, P_WBW, P_REP, P_FILL} ph_t;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    vec_t        tbl[$];

    // Expected output sets, one per situation described by the cache rules.
    function automatic out_t e_idle();
        out_t e = '0;
        e.rbuf = 1'b1; e.cache_ready = 1'b1;
        return e;
    endfunction
    function automatic out_t e_hit(logic op, logic [3:0] w);
        out_t e = e_idle();
        e.rdata_sel = 1'b1; e.pbuf = 1'b1; e.data_valid = 1'b1;
        e.way_visit = w; e.way_sel_en = 1'b1;
        if (op) begin e.mem_we = w; e.dirty_we = w; end
        return e;
    endfunction
    function automatic out_t e_lmiss();
        out_t e = '0;
        e.rdata_sel = 1'b1; e.pbuf = 1'b1; e.mbuf = 1'b1;
        return e;
    endfunction
    function automatic out_t e_miss(logic vd);
        out_t e = '0;
        e.wbuf = vd;
        return e;
    endfunction
    function automatic out_t e_wb();
        out_t e = '0;
        e.w_req = 1'b1;
        return e;
    endfunction
    function automatic out_t e_wbw(logic done_unc_store);
        out_t e = '0;
        if (done_unc_store) begin e.data_valid = 1'b1; e.rbuf = 1'b1; e.cache_ready = 1'b1; end
        return e;
    endfunction
    function automatic out_t e_rep();
        out_t e = '0;
        e.r_req = 1'b1;
        return e;
    endfunction
    function automatic out_t e_fill(logic ff, logic unc, logic [3:0] lru);
        out_t e = '0;
        e.r_data_ready = 1'b1;
        if (ff) begin
            e.data_valid = 1'b1; e.rbuf = 1'b1; e.cache_ready = 1'b1;
            if (!unc) begin
                e.mem_we = lru; e.tagv_we = lru; e.dirty_we = lru;
                e.way_visit = lru; e.way_sel_en = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic in_t mi(logic valid, logic op, logic unc, logic chit, logic [3:0] hit,
                               logic [3:0] lru, logic vd, logic rrdy, logic ff, logic wrdy,
                               logic wbd, logic clr);
        in_t x;
        x.valid = valid; x.op = op; x.unc = unc; x.chit = chit; x.hit = hit; x.lru = lru;
        x.vd = vd; x.rrdy = rrdy; x.ff = ff; x.wrdy = wrdy; x.wbd = wbd; x.clr = clr;
        return x;
    endfunction

    function automatic void add(string nm, in_t x, out_t e, int unsigned hc, int unsigned mc);
        vec_t v;
        v.name = nm; v.in = x; v.exp = e; v.hc = hc; v.mc = mc;
        tbl.push_back(v);
    endfunction

    task automatic apply(in_t x);
        bus.valid = x.valid; bus.op = x.op; bus.uncached = x.unc; bus.cache_hit = x.chit;
        bus.hit = x.hit; bus.lru_way_sel = x.lru; bus.victim_dirty = x.vd;
        bus.r_rdy_AXI = x.rrdy; bus.fill_finish = x.ff; bus.w_rdy_AXI = x.wrdy;
        bus.wb_done = x.wbd; bus.cnt_clr = x.clr;
    endtask

    function automatic out_t act();
        out_t a;
        a.way_visit = bus.way_visit; a.mbuf = bus.mbuf_we; a.pbuf = bus.pbuf_we;
        a.rbuf = bus.rbuf_we; a.wbuf = bus.wbuf_we; a.rdata_sel = bus.rdata_sel;
        a.way_sel_en = bus.way_sel_en; a.mem_we = bus.mem_we; a.tagv_we = bus.tagv_we;
        a.dirty_we = bus.dirty_we; a.r_req = bus.r_req; a.w_req = bus.w_req;
        a.r_data_ready = bus.r_data_ready; a.data_valid = bus.data_valid;
        a.cache_ready = bus.cache_ready;
        return a;
    endfunction

    task automatic chk_out(string nm, out_t a, out_t e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: outputs got %h expected %h", nm, a, e);
    endtask

    task automatic chk_cnt(string nm, logic [CNT_W-1:0] a, int unsigned e);
        logic [CNT_W-1:0] ev;
        ev = CNT_W'(e);
        n_chk++;
        if (a === ev) n_pass++;
        else $display("FAIL %s: count got %0d expected %0d", nm, a, ev);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply('0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Transaction-level reference: one call per cycle, returns the cycle's outputs,
    // next phase and which counter the request bumps.
    task automatic model(input in_t x, input ph_t ph, output out_t e, output ph_t nph,
                         output logic ih, output logic im);
        ih = 1'b0; im = 1'b0; e = '0; nph = P_IDLE;
        case (ph)
            P_IDLE: begin e = e_idle(); nph = x.valid ? P_LOOK : P_IDLE; end
            P_LOOK: begin
                if (x.unc) begin e = e_lmiss(); nph = x.op ? P_WB : P_REP; end
                else if (x.chit) begin
                    e = e_hit(x.op, x.hit); ih = 1'b1; nph = x.valid ? P_LOOK : P_IDLE;
                end else begin e = e_lmiss(); im = 1'b1; nph = P_MISS; end
            end
            P_MISS: begin e = e_miss(x.vd); nph = x.vd ? P_WB : P_REP; end
            P_WB:   begin e = e_wb(); nph = x.wrdy ? P_WBW : P_WB; end
            P_WBW: begin
                e = e_wbw(x.wbd && x.unc && x.op);
                if (!x.wbd) nph = P_WBW;
                else if (x.unc && x.op) nph = x.valid ? P_LOOK : P_IDLE;
                else nph = P_REP;
            end
            P_REP:  begin e = e_rep(); nph = x.rrdy ? P_FILL : P_REP; end
            P_FILL: begin
                e = e_fill(x.ff, x.unc, x.lru);
                nph = x.ff ? (x.valid ? P_LOOK : P_IDLE) : P_FILL;
            end
            default: nph = P_IDLE;
        endcase
    endtask

    initial begin
        // Load hit then store hit with valid held.
        add("t2_idle",      mi(1,0,0,0,4'b0000,4'b0001,0,0,0,0,0,0), e_idle(), 0, 0);
        add("t2_ld_hit",    mi(1,0,0,1,4'b0100,4'b0001,0,0,0,0,0,0), e_hit(0, 4'b0100), 0, 0);
        add("t2_st_hit",    mi(0,1,0,1,4'b0100,4'b0001,0,0,0,0,0,0), e_hit(1, 4'b0100), 1, 0);
        add("t2_idle_end",  mi(0,0,0,0,4'b0000,4'b0001,0,0,0,0,0,0), e_idle(), 2, 0);
        // Clean load miss: 3 REPLACE cycles, 5 REFILL cycles.
        add("t3_idle",      mi(1,0,0,0,4'b0000,4'b0001,0,0,0,0,0,0), e_idle(), 2, 0);
        add("t3_lookup",    mi(0,0,0,0,4'b0000,4'b0001,0,0,0,0,0,0), e_lmiss(), 2, 0);
        add("t3_miss",      mi(0,0,0,0,4'b0000,4'b0001,0,0,0,0,0,0), e_miss(0), 2, 1);
        for (int i = 0; i < 3; i++)
            add("t3_replace", mi(0,0,0,0,4'b0000,4'b0001,0,(i == 2),0,0,0,0), e_rep(), 2, 1);
        for (int i = 0; i < 5; i++)
            add("t3_refill", mi(0,0,0,0,4'b0000,4'b0001,0,0,(i == 4),0,0,0),
                e_fill((i == 4), 0, 4'b0001), 2, 1);
        add("t3_idle_end",  mi(0,0,0,0,4'b0000,4'b0001,0,0,0,0,0,0), e_idle(), 2, 1);
        // Dirty store miss; w_rdy and wb_done together in WRITEBACK must not skip WB_WAIT.
        add("t4_idle",      mi(1,1,0,0,4'b0000,4'b1000,1,0,0,0,0,0), e_idle(), 2, 1);
        add("t4_lookup",    mi(0,1,0,0,4'b0000,4'b1000,1,0,0,0,0,0), e_lmiss(), 2, 1);
        add("t4_miss",      mi(0,1,0,0,4'b0000,4'b1000,1,0,0,0,0,0), e_miss(1), 2, 2);
        add("t4_wb_wait",   mi(0,1,0,0,4'b0000,4'b1000,1,0,0,0,0,0), e_wb(), 2, 2);
        add("t4_wb_rdy",    mi(0,1,0,0,4'b0000,4'b1000,1,0,0,1,1,0), e_wb(), 2, 2);
        add("t4_wbw_0",     mi(0,1,0,0,4'b0000,4'b1000,1,0,0,0,0,0), e_wbw(0), 2, 2);
        add("t4_wbw_done",  mi(0,1,0,0,4'b0000,4'b1000,1,0,0,0,1,0), e_wbw(0), 2, 2);
        add("t4_replace",   mi(0,1,0,0,4'b0000,4'b1000,1,1,0,0,0,0), e_rep(), 2, 2);
        add("t4_refill",    mi(0,1,0,0,4'b0000,4'b1000,1,0,1,0,0,0), e_fill(1, 0, 4'b1000), 2, 2);
        add("t4_idle_end",  mi(0,0,0,0,4'b0000,4'b1000,0,0,0,0,0,0), e_idle(), 2, 2);
        // Uncached load (cache_hit ignored) chained into uncached store.
        add("t5_idle",      mi(1,0,1,1,4'b0010,4'b0001,0,0,0,0,0,0), e_idle(), 2, 2);
        add("t5_ld_lookup", mi(0,0,1,1,4'b0010,4'b0001,0,0,0,0,0,0), e_lmiss(), 2, 2);
        add("t5_ld_replace",mi(0,0,1,1,4'b0010,4'b0001,0,1,0,0,0,0), e_rep(), 2, 2);
        add("t5_ld_refill", mi(0,0,1,1,4'b0010,4'b0001,0,0,0,0,0,0), e_fill(0, 1, 4'b0001), 2, 2);
        add("t5_ld_done",   mi(1,0,1,1,4'b0010,4'b0001,0,0,1,0,0,0), e_fill(1, 1, 4'b0001), 2, 2);
        add("t5_st_lookup", mi(0,1,1,1,4'b0010,4'b0001,0,0,0,0,0,0), e_lmiss(), 2, 2);
        add("t5_st_wb",     mi(0,1,1,1,4'b0010,4'b0001,0,0,0,1,0,0), e_wb(), 2, 2);
        add("t5_st_wbw",    mi(0,1,1,1,4'b0010,4'b0001,0,0,0,0,0,0), e_wbw(0), 2, 2);
        add("t5_st_done",   mi(0,1,1,1,4'b0010,4'b0001,0,0,0,0,1,0), e_wbw(1), 2, 2);
        add("t5_idle_end",  mi(0,0,0,0,4'b0000,4'b0001,0,0,0,0,0,0), e_idle(), 2, 2);

        do_reset();
        chk_out("reset_out", act(), e_idle());
        chk_cnt("reset_hit_cnt", bus.hit_cnt, 0);
        chk_cnt("reset_miss_cnt", bus.miss_cnt, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].in);
            #4;
            chk_out(tbl[i].name, act(), tbl[i].exp);
            chk_cnt({tbl[i].name, "_hc"}, bus.hit_cnt, tbl[i].hc);
            chk_cnt({tbl[i].name, "_mc"}, bus.miss_cnt, tbl[i].mc);
            tick();
        end

        // Asynchronous reset while in REFILL abandons the miss.
        apply(mi(1,0,0,0,4'b0000,4'b0010,0,0,0,0,0,0)); tick();
        apply(mi(0,0,0,0,4'b0000,4'b0010,0,0,0,0,0,0)); tick();
        tick();
        apply(mi(0,0,0,0,4'b0000,4'b0010,0,1,0,0,0,0)); tick();
        apply(mi(0,0,0,0,4'b0000,4'b0010,0,0,0,0,0,0));
        #1;
        chk_out("t1_in_refill", act(), e_fill(0, 0, 4'b0010));
        chk_cnt("t1_mc_before", bus.miss_cnt, 3);
        rst = 1'b1;
        #1;
        chk_out("t1_async_rst", act(), e_idle());
        chk_cnt("t1_async_hc", bus.hit_cnt, 0);
        chk_cnt("t1_async_mc", bus.miss_cnt, 0);
        tick();
        rst = 1'b0;
        #3;
        chk_out("t1_after_edge", act(), e_idle());
        tick();
        chk_out("t1_stays_idle", act(), e_idle());

        // Saturation with CNT_W=4, then clear beats a simultaneous hit.
        apply(mi(1,0,0,1,4'b0100,4'b0001,0,0,0,0,0,0)); tick();
        for (int i = 0; i < 20; i++) tick();
        #3;
        chk_out("t6_hit_held", act(), e_hit(0, 4'b0100));
        chk_cnt("t6_sat_hc", bus.hit_cnt, CNT_MAX);
        chk_cnt("t6_sat_mc", bus.miss_cnt, 0);
        apply(mi(1,0,0,1,4'b0100,4'b0001,0,0,0,0,0,1));
        tick();
        apply(mi(0,0,0,1,4'b0100,4'b0001,0,0,0,0,0,0));
        chk_cnt("t6_clr_hc", bus.hit_cnt, 0);
        tick();
        chk_cnt("t6_after_clr_hc", bus.hit_cnt, 1);
        chk_out("t6_back_idle", act(), e_idle());

        // Random traffic against the reference model.
        begin
            ph_t         ph;
            ph_t         nph;
            out_t        e;
            in_t         x;
            logic        ih;
            logic        im;
            logic        allow;
            logic        r_op;
            logic        r_unc;
            int unsigned mhc;
            int unsigned mmc;
            do_reset();
            ph = P_IDLE; mhc = 0; mmc = 0; allow = 1'b1; r_op = 1'b0; r_unc = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                if (allow) begin
                    r_op  = 1'($urandom % 2);
                    r_unc = ($urandom % 4) == 0;
                end
                x = mi(1'($urandom % 2), r_op, r_unc, 1'($urandom % 2),
                       4'(1 << ($urandom % 4)), 4'(1 << ($urandom % 4)), 1'($urandom % 2),
                       ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                       ($urandom % 3) == 0, ($urandom % 64) == 0);
                model(x, ph, e, nph, ih, im);
                apply(x);
                #4;
                chk_out("rnd_out", act(), e);
                chk_cnt("rnd_hc", bus.hit_cnt, mhc);
                chk_cnt("rnd_mc", bus.miss_cnt, mmc);
                if (x.clr) begin
                    mhc = 0; mmc = 0;
                end else begin
                    if (ih && mhc < CNT_MAX) mhc++;
                    if (im && mmc < CNT_MAX) mmc++;
                end
                ph = nph;
                allow = e.cache_ready;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
